rng_req_arbiter: RTL and testbench

Round-robin scheduler that shares the single 32-bit TRNG AXI Stream output among NREQ independent consumers. Each consumer requests a fixed number of random words. The arbiter grants one requester at a time and routes exactly that many words to it with zero-latency pass-through. It then signals completion and moves to the next requester. It sits between the TRNG top-level stream output and on-chip consumers (key generators, nonce engines, DMA front-ends).

---
 rtl/rng_arb_pkg.sv | 18 +
 rtl/rng_rr_pick.sv | 45 ++++
 rtl/rng_req_arbiter.sv | 153 +++++++++++++++
 tb/tb_rng_req_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_arb_pkg.sv
// Shared types and defaults for the TRNG request arbiter.
//   arb_state_e : arbiter FSM state encoding (IDLE, XFER, FIN)
//   NREQ_DEF    : default number of requesters
//   CW_DEF      : default width of a per-request word count
//   NREQ_MAX    : largest supported number of requesters
package rng_arb_pkg;

    localparam int unsigned NREQ_MAX = 8;
    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned CW_DEF   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        FIN  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rng_rr_pick.sv
// Combinational round-robin picker: searches req_i starting at last_i+1
// (mod NREQ) and returns the first requester found.
//   req_i    : request vector
//   last_i   : index of the most recently served requester
//   gnt_oh_o : one-hot winner (zero when nothing is requested)
//   idx_o    : binary index of the winner
//   any_o    : at least one request present
module rng_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [NREQ-1:0] gnt_oh_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    logic          found;
    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    // Offsets 1..NREQ from last; the extra sum bit lets the wrap stay a single subtract.
    always_comb begin
        found = 1'b0;
        idx_o = '0;
        sum   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            sum = {1'b0, last_i} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            cand = sum[IW-1:0];
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
    end

    assign any_o    = found;
    assign gnt_oh_o = found ? (NREQ'(1) << idx_o) : '0;

endmodule

// File: rtl/rng_req_arbiter.sv
// Round-robin scheduler sharing one 32-bit TRNG stream among NREQ consumers.
// Each granted requester receives exactly its latched word count with
// zero-latency pass-through, then gets a one-cycle DONE pulse.
//   CLK, RST_X          : clock, asynchronous active-low reset
//   S_TDATA/TVALID/TREADY : TRNG stream input
//   REQ, REQ_WORDS      : per-requester request level and word count
//   GNT                 : one-hot grant while transferring
//   OUT_DATA/VALID/READY : shared data bus, per-requester handshake
//   DONE, ABORTED       : completion pulse, early-termination qualifier
//   BUSY                : arbiter not idle
// Optional feature: define RNG_ARB_ABORT_EN to let a requester end its
// transfer early by dropping REQ; otherwise ABORTED is constant 0.
module rng_req_arbiter
    import rng_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned CW   = CW_DEF
) (
    input  logic             CLK,
    input  logic             RST_X,
    input  logic [31:0]      S_TDATA,
    input  logic             S_TVALID,
    output logic             S_TREADY,
    input  logic [NREQ-1:0]  REQ,
    input  logic [NREQ*CW-1:0] REQ_WORDS,
    output logic [NREQ-1:0]  GNT,
    output logic [31:0]      OUT_DATA,
    output logic [NREQ-1:0]  OUT_VALID,
    input  logic [NREQ-1:0]  OUT_READY,
    output logic [NREQ-1:0]  DONE,
    output logic             ABORTED,
    output logic             BUSY
);

    localparam int unsigned IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_bad_nreq
        $error("rng_req_arbiter: NREQ out of range");
    end

    arb_state_e      state_q, state_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic [IW-1:0]   cur_q, cur_d;
    logic [IW-1:0]   last_q, last_d;
`ifdef RNG_ARB_ABORT_EN
    logic            abort_q, abort_d;
`endif

    logic [NREQ-1:0] pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [CW-1:0]   pick_words;

    rng_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req_i    (REQ),
        .last_i   (last_q),
        .gnt_oh_o (pick_oh),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    // Word count of the current round-robin winner.
    always_comb begin
        pick_words = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_oh[i]) begin
                pick_words = REQ_WORDS[i*CW +: CW];
            end
        end
    end

    assign OUT_DATA = S_TDATA;

    // State, counter and index registers.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q <= IDLE;
            rem_q   <= '0;
            cur_q   <= '0;
            last_q  <= IW'(NREQ - 1);
`ifdef RNG_ARB_ABORT_EN
            abort_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
`ifdef RNG_ARB_ABORT_EN
            abort_q <= abort_d;
`endif
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        cur_d     = cur_q;
        last_d    = last_q;
`ifdef RNG_ARB_ABORT_EN
        abort_d   = abort_q;
`endif
        GNT       = '0;
        OUT_VALID = '0;
        S_TREADY  = 1'b0;
        DONE      = '0;
        ABORTED   = 1'b0;
        BUSY      = 1'b1;

        case (state_q)
            IDLE: begin
                BUSY = 1'b0;
                if (pick_any) begin
                    cur_d   = pick_idx;
                    rem_d   = pick_words;
                    state_d = (pick_words != '0) ? XFER : FIN;
                end
            end
            XFER: begin
                GNT[cur_q]       = 1'b1;
                OUT_VALID[cur_q] = S_TVALID;
                S_TREADY         = OUT_READY[cur_q];
                if (S_TVALID && OUT_READY[cur_q]) begin
                    rem_d = rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        state_d = FIN;
                    end
                end
`ifdef RNG_ARB_ABORT_EN
                // A drop coinciding with the final word is a normal completion.
                if (!REQ[cur_q] && (state_d != FIN)) begin
                    state_d = FIN;
                    abort_d = 1'b1;
                end
`endif
            end
            FIN: begin
                DONE[cur_q] = 1'b1;
                last_d      = cur_q;
                state_d     = IDLE;
`ifdef RNG_ARB_ABORT_EN
                ABORTED     = abort_q;
                abort_d     = 1'b0;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rng_req_arbiter.sv
// Self-checking bench for rng_req_arbiter (NREQ=4, CW=16).
module tb_rng_req_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned CW   = 16;

    logic              CLK = 1'b0;
    logic              RST_X;
    logic [31:0]       S_TDATA;
    logic              S_TVALID;
    logic              S_TREADY;
    logic [NREQ-1:0]   REQ;
    logic [NREQ*CW-1:0] REQ_WORDS;
    logic [NREQ-1:0]   GNT;
    logic [31:0]       OUT_DATA;
    logic [NREQ-1:0]   OUT_VALID;
    logic [NREQ-1:0]   OUT_READY;
    logic [NREQ-1:0]   DONE;
    logic              ABORTED;
    logic              BUSY;

    rng_req_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
        .CLK       (CLK),
        .RST_X     (RST_X),
        .S_TDATA   (S_TDATA),
        .S_TVALID  (S_TVALID),
        .S_TREADY  (S_TREADY),
        .REQ       (REQ),
        .REQ_WORDS (REQ_WORDS),
        .GNT       (GNT),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .DONE      (DONE),
        .ABORTED   (ABORTED),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;
    int cycle    = 0;

    // Stimulus controls
    logic [NREQ-1:0] req_v;
    logic [CW-1:0]   words [NREQ];
    int              tv_mode;    // 0: always valid, 1: random, 2: never
    int              rdy_mode;   // 0: always ready, 1: random
    bit              auto_drop;  // requester drops REQ right after its DONE

    always_comb begin
        for (int i = 0; i < NREQ; i++) REQ_WORDS[i*CW +: CW] = words[i];
    end

    // Observation logs (reference model bookkeeping)
    int          done_q[$];
    int          done_cyc_q[$];
    bit          ab_q[$];
    int          xw_q[$];
    int          gnt_q[$];
    int          gnt_cyc_q[$];
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    int          hs_cnt [NREQ];
    int          xfer_words;
    int          last_hs_cyc;
    int          busy_fall_cyc;
    logic [NREQ-1:0] prev_gnt;
    bit          prev_busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [NREQ-1:0] v);
        int r = -1;
        for (int i = NREQ - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    task automatic clear_logs();
        done_q.delete(); done_cyc_q.delete(); ab_q.delete(); xw_q.delete();
        gnt_q.delete(); gnt_cyc_q.delete(); tx_q.delete(); rx_q.delete();
        for (int i = 0; i < NREQ; i++) hs_cnt[i] = 0;
        xfer_words    = 0;
        last_hs_cyc   = -1;
        busy_fall_cyc = -1;
        prev_gnt      = '0;
        prev_busy     = 1'b0;
    endtask

    // One clock cycle: drive at negedge, sample 1 time unit later, log events.
    task automatic cyc();
        @(negedge CLK);
        S_TDATA = $urandom;
        case (tv_mode)
            0:       S_TVALID = 1'b1;
            1:       S_TVALID = 1'($urandom_range(0, 1));
            default: S_TVALID = 1'b0;
        endcase
        OUT_READY = (rdy_mode == 1) ? NREQ'($urandom) : '1;
        REQ = req_v;
        #1;
        cycle++;
        chk("gnt_onehot", ($countones(GNT) <= 1), 1);
        chk("out_data_pass", OUT_DATA, S_TDATA);
        chk("tready_only_granted", S_TREADY, |(GNT & OUT_READY));
        chk("valid_only_granted", OUT_VALID, GNT & {NREQ{S_TVALID}});
        chk("aborted_needs_done", ABORTED & (DONE == '0), 0);
        chk("busy_when_active", ((GNT | DONE) != '0) & !BUSY, 0);
        if (S_TVALID && S_TREADY) tx_q.push_back(S_TDATA);
        for (int i = 0; i < NREQ; i++) begin
            if (OUT_VALID[i] && OUT_READY[i]) begin
                hs_cnt[i]++;
                rx_q.push_back(OUT_DATA);
                xfer_words++;
                last_hs_cyc = cycle;
            end
        end
        if (GNT != '0 && GNT != prev_gnt) begin
            gnt_q.push_back(idx_of(GNT));
            gnt_cyc_q.push_back(cycle);
        end
        if (DONE != '0) begin
            done_q.push_back(idx_of(DONE));
            done_cyc_q.push_back(cycle);
            ab_q.push_back(ABORTED);
            xw_q.push_back(xfer_words);
            xfer_words = 0;
            if (auto_drop) req_v &= ~DONE;
        end
        if (prev_busy && !BUSY) busy_fall_cyc = cycle;
        prev_gnt  = GNT;
        prev_busy = BUSY;
    endtask

    // Assert reset with live stimulus still applied; outputs must clear at once.
    task automatic do_reset();
        @(negedge CLK);
        RST_X = 1'b0;
        #1;
        chk("rst_gnt", GNT, 0);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_tready", S_TREADY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_aborted", ABORTED, 0);
        chk("rst_busy", BUSY, 0);
        REQ      = '0;
        req_v    = '0;
        S_TVALID = 1'b0;
        repeat (2) @(negedge CLK);
        RST_X = 1'b1;
        clear_logs();
    endtask

    // Words handed to requesters must equal words taken from the stream, in order.
    task automatic check_data(input string tag);
        chk({tag, "_count"}, rx_q.size(), tx_q.size());
        for (int i = 0; i < rx_q.size() && i < tx_q.size(); i++)
            chk({tag, "_word"}, rx_q[i], tx_q[i]);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int c0;
        int exp_o [5] = '{0, 1, 2, 3, 0};

        RST_X = 1'b0; S_TDATA = '0; S_TVALID = 1'b0; OUT_READY = '0; REQ = '0;
        req_v = '0; tv_mode = 0; rdy_mode = 0; auto_drop = 1'b1;
        foreach (words[i]) words[i] = '0;
        clear_logs();
        do_reset();

        // Single requester, 3 words, no stalls
        foreach (words[i]) words[i] = 16'd3;
        req_v = 4'b0001;
        c0 = cycle + 1;
        for (int k = 0; k < 30 && done_q.size() < 1; k++) cyc();
        repeat (2) cyc();
        chk("s1_done_count", done_q.size(), 1);
        chk("s1_grant_count", gnt_q.size(), 1);
        if (gnt_q.size() >= 1) begin
            chk("s1_grant_idx", gnt_q[0], 0);
            chk("s1_grant_cycle", gnt_cyc_q[0], c0 + 1);
        end
        chk("s1_hs_req0", hs_cnt[0], 3);
        chk("s1_hs_others", hs_cnt[1] + hs_cnt[2] + hs_cnt[3], 0);
        if (done_q.size() >= 1) begin
            chk("s1_done_idx", done_q[0], 0);
            chk("s1_done_latency", done_cyc_q[0], last_hs_cyc + 1);
            chk("s1_aborted", ab_q[0], 0);
        end
        chk("s1_busy_fall", busy_fall_cyc, last_hs_cyc + 2);
        check_data("s1_data");

        // All four requesting, 2 words each, REQ held high
        do_reset();
        foreach (words[i]) words[i] = 16'd2;
        auto_drop = 1'b0;
        req_v = 4'b1111;
        for (int k = 0; k < 80 && done_q.size() < 5; k++) cyc();
        req_v = '0;
        repeat (3) cyc();
        chk("s2_done_count", done_q.size(), 5);
        chk("s2_grant_count", gnt_q.size(), 5);
        for (int i = 0; i < 5 && i < gnt_q.size(); i++) chk("s2_grant_order", gnt_q[i], exp_o[i]);
        for (int i = 0; i < 5 && i < done_q.size(); i++) begin
            chk("s2_done_order", done_q[i], exp_o[i]);
            chk("s2_words_per_xfer", xw_q[i], 2);
        end
        chk("s2_hs_req0", hs_cnt[0], 4);
        check_data("s2_data");

        // Random stream and consumer stalls, requester 1, 5 words
        clear_logs();
        auto_drop = 1'b1;
        words[1] = 16'd5;
        tv_mode = 1; rdy_mode = 1;
        req_v = 4'b0010;
        for (int k = 0; k < 300 && done_q.size() < 1; k++) cyc();
        tv_mode = 0; rdy_mode = 0;
        cyc();
        chk("s3_done_count", done_q.size(), 1);
        if (done_q.size() >= 1) begin
            chk("s3_done_idx", done_q[0], 1);
            chk("s3_words_per_xfer", xw_q[0], 5);
        end
        chk("s3_hs_req1", hs_cnt[1], 5);
        check_data("s3_data");

        // Reset in the middle of a 10-word transfer after 7 words
        clear_logs();
        words[2] = 16'd10;
        req_v = 4'b0100;
        for (int k = 0; k < 40 && hs_cnt[2] < 7; k++) cyc();
        chk("s5_hs_before_reset", hs_cnt[2], 7);
        do_reset();
        cyc();
        chk("s5_no_done_after_reset", done_q.size(), 0);
        words[0] = 16'd1; words[3] = 16'd1;
        req_v = 4'b1001;
        for (int k = 0; k < 30 && done_q.size() < 2; k++) cyc();
        cyc();
        chk("s5_grant_count", gnt_q.size(), 2);
        if (gnt_q.size() >= 2) begin
            chk("s5_first_grant", gnt_q[0], 0);
            chk("s5_second_grant", gnt_q[1], 3);
        end
        chk("s5_done_count", done_q.size(), 2);

        // Zero-word request for requester 2, then requester 3
        clear_logs();
        words[2] = 16'd0; words[3] = 16'd2;
        req_v = 4'b1100;
        c0 = cycle + 1;
        for (int k = 0; k < 30 && done_q.size() < 2; k++) cyc();
        cyc();
        chk("s4_done_count", done_q.size(), 2);
        if (done_q.size() >= 2) begin
            chk("s4_done0_idx", done_q[0], 2);
            chk("s4_done0_cycle", done_cyc_q[0], c0 + 1);
            chk("s4_done0_words", xw_q[0], 0);
            chk("s4_done1_idx", done_q[1], 3);
        end
        chk("s4_grant_count", gnt_q.size(), 1);
        if (gnt_q.size() >= 1) begin
            chk("s4_grant_idx", gnt_q[0], 3);
            chk("s4_grant_cycle", gnt_cyc_q[0], c0 + 3);
        end
        chk("s4_hs_req2", hs_cnt[2], 0);
        chk("s4_hs_req3", hs_cnt[3], 2);

        // Requester 1 asks for 100 words and drops REQ after 10
        clear_logs();
        words[1] = 16'd100;
        req_v = 4'b0010;
        for (int k = 0; k < 60 && hs_cnt[1] < 10; k++) cyc();
        chk("s6_hs_before_drop", hs_cnt[1], 10);
        tv_mode = 2;
        req_v[1] = 1'b0;
        c0 = cycle + 1;
        cyc();
        tv_mode = 0;
        for (int k = 0; k < 200 && done_q.size() < 1; k++) cyc();
        cyc();
        chk("s6_done_count", done_q.size(), 1);
`ifdef RNG_ARB_ABORT_EN
        chk("s6_hs_req1", hs_cnt[1], 10);
        if (done_q.size() >= 1) begin
            chk("s6_done_idx", done_q[0], 1);
            chk("s6_aborted", ab_q[0], 1);
            chk("s6_done_cycle", done_cyc_q[0], c0 + 1);
            chk("s6_words_per_xfer", xw_q[0], 10);
        end
`else
        chk("s6_hs_req1", hs_cnt[1], 100);
        if (done_q.size() >= 1) begin
            chk("s6_done_idx", done_q[0], 1);
            chk("s6_aborted", ab_q[0], 0);
            chk("s6_words_per_xfer", xw_q[0], 100);
        end
`endif
        check_data("s6_data");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
